// File: rtl/rom_arb_pkg.sv
// Shared constants for the ROM arbiter: FSM encodings, default header magic,
// port identifiers and a helper that picks one byte of the header magic.
package rom_arb_pkg;

    localparam logic [2:0] S_CHK_ADDR = 3'd0;
    localparam logic [2:0] S_CHK_DATA = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_ADDR     = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h4153524D;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Byte 0 of the image is the most significant byte of the magic word.
    function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = magic[31:24];
            2'd1:    b = magic[23:16];
            2'd2:    b = magic[15:8];
            default: b = magic[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the ROM arbiter: two req/ack read ports.
interface rom_arbiter_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  req_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic                  ack_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  req_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  ack_b;
    logic [DATA_WIDTH-1:0] data_b;

    modport master (
        output req_a, addr_a, req_b, addr_b,
        input  ack_a, data_a, ack_b, data_b
    );

    modport slave (
        input  req_a, addr_a, req_b, addr_b,
        output ack_a, data_a, ack_b, data_b
    );
endinterface

// File: rtl/rom_rr_pick.sv
// Combinational two-way round-robin picker; any grant points the pointer
// at the port that was not granted.
module rom_rr_pick
    import rom_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic pointer,
    output logic grant_valid,
    output logic grant_sel,
    output logic next_pointer
);

    always_comb begin
        grant_valid  = req_a | req_b;
        grant_sel    = PORT_A;
        next_pointer = pointer;
        if (req_a && req_b)
            grant_sel = pointer;
        else if (req_b)
            grant_sel = PORT_B;
        if (grant_valid)
            next_pointer = ~grant_sel;
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read ROM between two requesters after checking the
// image header; one registered data word per req/ack transaction.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 7,
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] MAGIC       = DEFAULT_MAGIC,
    parameter bit          CHECK_MAGIC = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    rom_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_enable_out,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  boot_done,
    output logic                  rom_ok
);

    localparam logic [2:0] RESET_STATE = CHECK_MAGIC ? S_CHK_ADDR : S_IDLE;
    localparam logic       RESET_BOOT  = CHECK_MAGIC ? 1'b0 : 1'b1;

    logic [2:0]            state;
    logic [1:0]            cnt;
    logic                  match;
    logic                  pointer;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr_lat;
    logic [DATA_WIDTH-1:0] data_a_q;
    logic [DATA_WIDTH-1:0] data_b_q;
    logic                  byte_ok;
    logic                  grant_valid;
    logic                  grant_sel;
    logic                  next_pointer;

    rom_rr_pick u_pick (
        .req_a        (bus.req_a),
        .req_b        (bus.req_b),
        .pointer      (pointer),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .next_pointer (next_pointer)
    );

    assign byte_ok = (rom_data == DATA_WIDTH'(magic_byte(MAGIC, cnt)));

    // The address latch doubles as the ROM address register, so rom_addr
    // keeps its last value in every state that does not reload it.
    assign rom_addr       = addr_lat;
    assign rom_enable_out = (state == S_CHK_DATA) || ((state == S_DATA) && rom_ok);
    assign bus.ack_a      = (state == S_DONE) && (sel == PORT_A);
    assign bus.ack_b      = (state == S_DONE) && (sel == PORT_B);
    assign bus.data_a     = data_a_q;
    assign bus.data_b     = data_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            cnt       <= '0;
            match     <= 1'b1;
            pointer   <= PORT_A;
            sel       <= PORT_A;
            addr_lat  <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            boot_done <= RESET_BOOT;
            rom_ok    <= RESET_BOOT;
        end else begin
            case (state)
                S_CHK_ADDR: state <= S_CHK_DATA;
                S_CHK_DATA: begin
                    if (!byte_ok)
                        match <= 1'b0;
                    if (cnt == 2'd3) begin
                        boot_done <= 1'b1;
                        rom_ok    <= match && byte_ok;
                        state     <= S_IDLE;
                    end else begin
                        cnt      <= cnt + 2'd1;
                        addr_lat <= ADDR_WIDTH'(cnt + 2'd1);
                        state    <= S_CHK_ADDR;
                    end
                end
                S_IDLE: begin
                    if (grant_valid) begin
                        sel      <= grant_sel;
                        pointer  <= next_pointer;
                        addr_lat <= (grant_sel == PORT_B) ? bus.addr_b : bus.addr_a;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: state <= S_DATA;
                S_DATA: begin
                    if (sel == PORT_A)
                        data_a_q <= rom_ok ? rom_data : '0;
                    else
                        data_b_q <= rom_ok ? rom_data : '0;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: header check, single/contended reads,
// back-to-back reads, mid-transaction reset and a bad image.
module tb_rom_arbiter;

    logic       clk;
    logic       reset;
    logic [6:0] rom_addr;
    logic       rom_enable_out;
    logic [7:0] rom_data;
    logic       boot_done;
    logic       rom_ok;
    logic [7:0] rom_q;
    logic [7:0] mem [0:127];

    int n_checks = 0;
    int n_errors = 0;

    rom_arbiter_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    rom_arbiter #(
        .ADDR_WIDTH  (7),
        .DATA_WIDTH  (8),
        .MAGIC       (32'h4153524D),
        .CHECK_MAGIC (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rom_addr       (rom_addr),
        .rom_enable_out (rom_enable_out),
        .rom_data       (rom_data),
        .boot_done      (boot_done),
        .rom_ok         (rom_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read ROM: address sampled every edge, output zero when disabled.
    always @(posedge clk) rom_q <= mem[rom_addr];
    assign rom_data = rom_enable_out ? rom_q : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Releases reset on a falling edge (cycle 0) and watches the header check.
    task automatic boot_release(input string tag, input logic exp_ok);
        int en_cnt = 0;
        int acks = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (rom_enable_out) en_cnt++;
            if (bus.ack_a || bus.ack_b) acks++;
            if (i == 7) check({tag, "_boot_c7"}, 32'(boot_done), 32'd0);
            if (i == 8) begin
                check({tag, "_boot_c8"}, 32'(boot_done), 32'd1);
                check({tag, "_rom_ok"}, 32'(rom_ok), 32'(exp_ok));
            end
            @(negedge clk);
        end
        check({tag, "_en_pulses"}, 32'(en_cnt), 32'd4);
        check({tag, "_no_ack_boot"}, 32'(acks), 32'd0);
    endtask

    task automatic boot(input string tag, input logic exp_ok);
        @(negedge clk);
        reset = 1'b0;
        boot_release(tag, exp_ok);
    endtask

    // Starts in an IDLE cycle (cycle 0) and waits for the single ack.
    task automatic read_one(input string tag, input logic port, input logic [6:0] addr,
                            input logic [7:0] exp_data, input logic exp_en);
        int got_cycle = 0;
        int other = 0;
        int en_seen = 0;
        logic [7:0] got_data = 8'h00;
        if (port) begin
            bus.req_b = 1'b1; bus.addr_b = addr;
        end else begin
            bus.req_a = 1'b1; bus.addr_a = addr;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rom_enable_out) en_seen++;
            if (port ? bus.ack_a : bus.ack_b) other++;
            if (port ? bus.ack_b : bus.ack_a) begin
                got_cycle = k;
                got_data = port ? bus.data_b : bus.data_a;
                break;
            end
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        check({tag, "_ack_cycle"}, 32'(got_cycle), 32'd3);
        check({tag, "_data"}, 32'(got_data), 32'(exp_data));
        check({tag, "_other_ack"}, 32'(other), 32'd0);
        if (!exp_en) check({tag, "_rom_en"}, 32'(en_seen), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int ta [3];
        int tb [3];
        logic [7:0] da [3];
        logic [7:0] db [3];
        int na;
        int nb;
        int both;

        reset = 1'b0;
        bus.req_a = 1'b0; bus.addr_a = '0;
        bus.req_b = 1'b0; bus.addr_b = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[0] = 8'h41; mem[1] = 8'h53; mem[2] = 8'h52; mem[3] = 8'h4D;
        mem[5] = 8'h3C; mem[9] = 8'h7B; mem[10] = 8'hAC;
        mem[14] = 8'h3F; mem[15] = 8'h14; mem[16] = 8'h3C;

        #1;
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_ack_a", 32'(bus.ack_a), 32'd0);
        check("rst_rom_en", 32'(rom_enable_out), 32'd0);

        boot("good", 1'b1);
        read_one("single_a", 1'b0, 7'h05, 8'h3C, 1'b1);

        // Fresh pointer (A) for the contention scenario; both requests held.
        boot("good2", 1'b1);
        na = 0; nb = 0; both = 0;
        bus.req_a = 1'b1; bus.addr_a = 7'h09;
        bus.req_b = 1'b1; bus.addr_b = 7'h0A;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.ack_a && bus.ack_b) both++;
            if (bus.ack_a && na < 3) begin ta[na] = k; da[na] = bus.data_a; na++; end
            if (bus.ack_b && nb < 3) begin tb[nb] = k; db[nb] = bus.data_b; nb++; end
            if (k == 11) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
        end
        check("pair_na", 32'(na), 32'd2);
        check("pair_nb", 32'(nb), 32'd1);
        if (na == 2 && nb == 1) begin
            check("pair_a1_cycle", 32'(ta[0]), 32'd3);
            check("pair_a1_data", 32'(da[0]), 32'h7B);
            check("pair_b_cycle", 32'(tb[0]), 32'd7);
            check("pair_b_data", 32'(db[0]), 32'hAC);
            check("pair_a2_cycle", 32'(ta[1]), 32'd11);
        end
        check("pair_both_ack", 32'(both), 32'd0);

        // Port B held through three back-to-back reads, address changes on ack.
        nb = 0;
        bus.req_b = 1'b1; bus.addr_b = 7'h0E;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.ack_a) check("burst_ack_a", 32'(bus.ack_a), 32'd0);
            if (bus.ack_b && nb < 3) begin
                tb[nb] = k; db[nb] = bus.data_b; nb++;
                if (nb == 1) bus.addr_b = 7'h0F;
                if (nb == 2) bus.addr_b = 7'h10;
                if (nb == 3) bus.req_b = 1'b0;
            end
        end
        bus.req_b = 1'b0;
        check("burst_n", 32'(nb), 32'd3);
        if (nb == 3) begin
            check("burst_c1", 32'(tb[0]), 32'd3);
            check("burst_c2", 32'(tb[1]), 32'd7);
            check("burst_c3", 32'(tb[2]), 32'd11);
            check("burst_d1", 32'(db[0]), 32'h3F);
            check("burst_d2", 32'(db[1]), 32'h14);
            check("burst_d3", 32'(db[2]), 32'h3C);
        end

        // Reset asserted in the DATA cycle of a port A read.
        bus.req_a = 1'b1; bus.addr_a = 7'h09;
        repeat (2) @(negedge clk);
        check("mid_in_data", 32'(rom_enable_out), 32'd1);
        reset = 1'b0;
        bus.req_a = 1'b0;
        #1;
        check("mid_ack_a", 32'(bus.ack_a), 32'd0);
        check("mid_ack_b", 32'(bus.ack_b), 32'd0);
        check("mid_data_a", 32'(bus.data_a), 32'd0);
        check("mid_data_b", 32'(bus.data_b), 32'd0);
        check("mid_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rom_en", 32'(rom_enable_out), 32'd0);
        check("mid_boot_done", 32'(boot_done), 32'd0);
        check("mid_rom_ok", 32'(rom_ok), 32'd0);
        boot_release("mid_reboot", 1'b1);
        check("mid_data_a_after", 32'(bus.data_a), 32'd0);

        // Corrupted header byte 2.
        mem[2] = 8'h00;
        boot("bad", 1'b0);
        read_one("bad_read_a", 1'b0, 7'h05, 8'h00, 1'b0);
        mem[2] = 8'h52;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
